// File: rtl/fault_injector.sv
// ---------------------------------------------------------------------------
// fault_injector
//
// Injects a single-bit fault (bit-flip, stuck-at-0, stuck-at-1) into one of
// NREP redundant 32-bit replica words on their way to a downstream voter.
// A request is accepted in IDLE, waits `delay` cycles, applies the fault for
// `duration` cycles (0 = until `clear`), then signals completion with a
// one-cycle `done` pulse.
//
// Parameters
//   NREP        number of replicas (1..8)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   start       injection request, accepted only in IDLE with clear low
//   mode        00 bit-flip, 01 stuck-at-0, 10 stuck-at-1, 11 none
//   target      replica index to corrupt
//   bitsel      bit index within the replica word
//   delay       cycles from accept to fault onset
//   duration    cycles the fault is held, 0 = permanent until clear
//   clear       abort a pending fault or remove an applied one
//   din         replica words, replica i at [i*32+31:i*32]
//   dout        din with the fault applied (combinational path)
//   busy        state is not IDLE
//   active      fault currently applied
//   done        one-cycle pulse when an injection completes
//   inj_bit     bit index latched at accept
//   inj_count   saturating count of faults actually applied
//
// Build option
//   FAULT_INJ_LFSR_EN  when defined, the bit index comes from a free-running
//                      16-bit Fibonacci LFSR (taps 16,14,13,11, seed ACE1)
//                      instead of bitsel.
// ---------------------------------------------------------------------------
module fault_injector #(
    parameter int unsigned NREP = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [2:0]          target,
    input  logic [4:0]          bitsel,
    input  logic [7:0]          delay,
    input  logic [7:0]          duration,
    input  logic                clear,
    input  logic [NREP*32-1:0]  din,
    output logic [NREP*32-1:0]  dout,
    output logic                busy,
    output logic                active,
    output logic                done,
    output logic [4:0]          inj_bit,
    output logic [7:0]          inj_count
);

    localparam logic [3:0] NREP_W = 4'(NREP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_INJECT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [2:0]  target_q, target_d;
    logic [4:0]  bit_q, bit_d;
    logic [7:0]  dur_q, dur_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic [4:0]  bit_src;

    // A fault only counts and only corrupts when it addresses an existing
    // replica with a real fault type.
    function automatic logic fault_valid(input logic [1:0] m, input logic [2:0] t);
        return ({1'b0, t} < NREP_W) && (m != 2'b11);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef FAULT_INJ_LFSR_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;
    logic        unused_bitsel;

    assign lfsr_fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign unused_bitsel = ^bitsel;
    assign bit_src       = lfsr_q[4:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end
`else
    assign bit_src = bitsel;
`endif

    // Next-state logic. cnt_q counts down the remaining cycles of the current
    // timed phase; the phase ends on the cycle where it reads 1.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        bit_d    = bit_q;
        dur_d    = dur_q;
        cnt_d    = cnt_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (start && !clear) begin
                    mode_d   = mode;
                    target_d = target;
                    bit_d    = bit_src;
                    dur_d    = duration;
                    if (delay == 8'd0) begin
                        state_d = S_INJECT;
                        cnt_d   = duration;
                        if (fault_valid(mode, target)) begin
                            count_d = sat_inc(count_q);
                        end
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = delay;
                    end
                end
            end
            S_DELAY: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 8'd1) begin
                    state_d = S_INJECT;
                    cnt_d   = dur_q;
                    if (fault_valid(mode_q, target_q)) begin
                        count_d = sat_inc(count_q);
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_INJECT: begin
                if (clear || (dur_q != 8'd0 && cnt_q == 8'd1)) begin
                    state_d = S_DONE;
                end else if (dur_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        active_d = (state_d == S_INJECT);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            target_q <= '0;
            bit_q    <= '0;
            dur_q    <= '0;
            cnt_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            bit_q    <= bit_d;
            dur_q    <= dur_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Zero-latency data path: only the targeted replica, only while active.
    always_comb begin
        dout = din;
        if (active_q && fault_valid(mode_q, target_q)) begin
            for (int unsigned i = 0; i < NREP; i++) begin
                if (target_q == 3'(i)) begin
                    case (mode_q)
                        2'b00:   dout[i*32 + 32'(bit_q)] = ~din[i*32 + 32'(bit_q)];
                        2'b01:   dout[i*32 + 32'(bit_q)] = 1'b0;
                        2'b10:   dout[i*32 + 32'(bit_q)] = 1'b1;
                        default: dout[i*32 + 32'(bit_q)] = din[i*32 + 32'(bit_q)];
                    endcase
                end
            end
        end
    end

    assign busy      = busy_q;
    assign active    = active_q;
    assign done      = done_q;
    assign inj_bit   = bit_q;
    assign inj_count = count_q;

endmodule

// File: tb/tb_fault_injector.sv
// ---------------------------------------------------------------------------
// tb_fault_injector
//
// Each transaction is described by its timing rules (accept cycle 0, onset
// at 1+delay, hold for duration or until clear, done one cycle after the
// last applied cycle). The driver derives the expected outputs of every
// cycle from those rules and queues them; a monitor on the falling edge
// pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_fault_injector;

    localparam int unsigned NREP = 6;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          mode = '0;
    logic [2:0]          target = '0;
    logic [4:0]          bitsel = '0;
    logic [7:0]          delay = '0;
    logic [7:0]          duration = '0;
    logic                clear = 1'b0;
    logic [NREP*32-1:0]  din = '0;
    logic [NREP*32-1:0]  dout;
    logic                busy, active, done;
    logic [4:0]          inj_bit;
    logic [7:0]          inj_count;

    fault_injector #(.NREP(NREP)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .target    (target),
        .bitsel    (bitsel),
        .delay     (delay),
        .duration  (duration),
        .clear     (clear),
        .din       (din),
        .dout      (dout),
        .busy      (busy),
        .active    (active),
        .done      (done),
        .inj_bit   (inj_bit),
        .inj_count (inj_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               busy;
        logic               active;
        logic               done;
        logic [4:0]         ibit;
        logic [7:0]         cnt;
        logic [NREP*32-1:0] dout;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          cnt_model = 0;
    logic [4:0]  bit_model = '0;
    logic [15:0] tb_lfsr = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Fault rules applied to a replica word.
    function automatic logic [NREP*32-1:0] apply_fault(input logic [NREP*32-1:0] d,
                                                       input int md, input int tg, input int b);
        logic [NREP*32-1:0] r;
        logic [31:0] w;
        logic [31:0] m;
        r = d;
        w = d[tg*32 +: 32];
        m = 32'd1 << b;
        if (md == 0) w = w ^ m;
        else if (md == 1) w = w & ~m;
        else if (md == 2) w = w | m;
        r[tg*32 +: 32] = w;
        return r;
    endfunction

    function automatic logic [NREP*32-1:0] rand_din();
        logic [NREP*32-1:0] r;
        for (int i = 0; i < int'(NREP); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            chk("busy", 32'(busy), 32'(mon_e.busy));
            chk("active", 32'(active), 32'(mon_e.active));
            chk("done", 32'(done), 32'(mon_e.done));
            chk("inj_bit", 32'(inj_bit), 32'(mon_e.ibit));
            chk("inj_count", 32'(inj_count), 32'(mon_e.cnt));
            compared++;
            if (dout !== mon_e.dout) begin
                mismatched++;
                $display("FAIL dout cyc=%0d got=%h want=%h", cyc, dout, mon_e.dout);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!reset) tb_lfsr = lfsr_step(tb_lfsr);
        #1;
    endtask

    task automatic push_idle();
        exp_t x;
        x.busy   = 1'b0;
        x.active = 1'b0;
        x.done   = 1'b0;
        x.ibit   = bit_model;
        x.cnt    = 8'(cnt_model);
        x.dout   = din;
        expq.push_back(x);
    endtask

    // One idle cycle; with both=1 start and clear collide and nothing may be accepted.
    task automatic idle_cycle(input bit both);
        tick();
        start = both;
        clear = both;
        mode = 2'($urandom_range(0, 3));
        target = 3'($urandom_range(0, 7));
        delay = 8'($urandom_range(0, 3));
        din = rand_din();
        push_idle();
    endtask

    // noise: 0 none, 1 random ignored starts while busy, 2 ignored start at cycle 1
    task automatic run_txn(input int md, input int tg, input int bs, input int dly,
                           input int dur, input int clr_at, input int rst_at,
                           input int noise, input bit zero_din);
        int onset, e, idle_at, len;
        bit aborted, valid, in_rst;
        logic [4:0] lbit;
        exp_t x;
        lbit    = '0;
        onset   = 1 + dly;
        aborted = (dly > 0) && (clr_at >= 1) && (clr_at <= dly);
        e       = 1 << 20;
        if (aborted) begin
            idle_at = clr_at + 1;
        end else begin
            if (dur > 0) begin
                e = onset + dur - 1;
                if (clr_at >= onset && clr_at < e) e = clr_at;
            end else if (clr_at > 0) begin
                e = clr_at;
            end
            idle_at = e + 2;
        end
        len   = (rst_at > 0) ? rst_at + 1 : ((idle_at > clr_at + 1) ? idle_at : clr_at + 1);
        valid = (tg < int'(NREP)) && (md != 3);
        for (int k = 0; k <= len; k++) begin
            tick();
            if (rst_at > 0 && k == rst_at + 1) reset = 1'b0;
            start = 1'b0;
            clear = 1'b0;
            if (k == 0) begin
                mode = 2'(md); target = 3'(tg); bitsel = 5'(bs);
                delay = 8'(dly); duration = 8'(dur); start = 1'b1;
`ifdef FAULT_INJ_LFSR_EN
                lbit = tb_lfsr[4:0];
`else
                lbit = 5'(bs);
`endif
            end else if (k < idle_at && (rst_at == 0 || k < rst_at) &&
                         ((noise == 1 && $urandom_range(0, 2) == 0) || (noise == 2 && k == 1))) begin
                start = 1'b1;
                mode = 2'($urandom_range(0, 3)); target = 3'($urandom_range(0, 7));
                bitsel = 5'($urandom_range(0, 31)); delay = 8'($urandom_range(0, 3));
                duration = 8'($urandom_range(0, 3));
            end
            if (clr_at > 0 && k == clr_at) clear = 1'b1;
            din = zero_din ? '0 : rand_din();
            if (rst_at > 0 && k == rst_at) begin
                reset = 1'b1;
                tb_lfsr = 16'hACE1;
                cnt_model = 0;
                bit_model = '0;
            end
            in_rst = (rst_at > 0) && (k >= rst_at);
            if (!in_rst && !aborted && valid && k == onset && cnt_model < 255) cnt_model++;
            if (!in_rst && k == 1) bit_model = lbit;
            x.busy   = !in_rst && k >= 1 && k < idle_at;
            x.active = !in_rst && !aborted && k >= onset && k <= e;
            x.done   = !in_rst && !aborted && k == e + 1;
            x.ibit   = bit_model;
            x.cnt    = 8'(cnt_model);
            x.dout   = (x.active && valid) ? apply_fault(din, md, tg, int'(bit_model)) : din;
            expq.push_back(x);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int md, tg, bs, dly, dur, clr;
        din = rand_din();
        repeat (2) begin
            tick();
            din = rand_din();
            push_idle();
        end
        tick();
        reset = 1'b0;
        din = rand_din();
        push_idle();

        // zero din, bit-flip of bit 7 in replica 2, cycles 4-5, done at 6
        run_txn(0, 2, 7, 3, 2, 0, 0, 0, 1'b1);
        // stuck-at-1 on bit 31 of replica 5 until clear at cycle 20
        run_txn(2, 5, 31, 0, 0, 20, 0, 0, 1'b1);
        // second start during DELAY ignored, clear in DELAY aborts silently
        run_txn(0, 1, 3, 10, 3, 5, 0, 2, 1'b0);
        // out-of-range target: full sequence, no corruption, no count
        run_txn(0, 6, 9, 0, 1, 0, 0, 0, 1'b0);
        // mode 11: no corruption, no count
        run_txn(3, 0, 4, 2, 2, 0, 0, 0, 1'b0);
        // clear and start together in IDLE
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        // longest delay and duration
        run_txn(1, 0, 0, 255, 255, 0, 0, 0, 1'b0);
        // reset while a permanent fault is applied
        run_txn(2, 1, 17, 1, 0, 0, 3, 0, 1'b0);

        repeat (450) begin
            repeat ($urandom_range(0, 2)) idle_cycle(1'($urandom_range(0, 1)));
            md  = $urandom_range(0, 3);
            tg  = $urandom_range(0, 6);
            bs  = $urandom_range(0, 31);
            dly = $urandom_range(0, 4);
            dur = $urandom_range(0, 4);
            if (dur == 0) clr = 1 + dly + $urandom_range(0, 5);
            else clr = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, dly + dur + 2);
            run_txn(md, tg, bs, dly, dur, clr, 0, 1, 1'b0);
        end

        idle_cycle(1'b0);
        @(negedge clk);
        #1;
        compared++;
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL drain cyc=%0d got=%0d want=0", cyc, expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
